// File: rtl/updown_pulse_gen.sv
// Up/Down button front end: sync, debounce, rising-edge strobes with mutual exclusion.
// Optional hold-to-repeat per channel when AUTOREPEAT_EN is defined.
module updown_pulse_gen #(
  parameter int DB_CYCLES     = 50000,
  parameter int HOLD_CYCLES   = 25000000,
  parameter int REPEAT_CYCLES = 5000000
) (
  input  logic clk,
  input  logic sys_reset_n,
  input  logic btn_up_raw,
  input  logic btn_down_raw,
  output logic up_pulse,
  output logic down_pulse,
  output logic up_held,
  output logic down_held
);
  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

  // Channel index 0 = Up, 1 = Down.
  logic [1:0]     raw;
  logic [1:0]     sync1_q, sync2_q;
  logic [1:0]     stable_q, stable_d;
  logic [1:0]     prev_q;
  logic [1:0]     pulse_q, pulse_d;
  logic [1:0]     other_held;
  logic [1:0]     edge_det;
  logic [1:0]     rpt_pulse;
  logic [DBW-1:0] db_cnt_q [2];
  logic [DBW-1:0] db_cnt_d [2];

  assign raw        = {btn_down_raw, btn_up_raw};
  assign other_held = {stable_q[0], stable_q[1]};

  always_ff @(posedge clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      stable_q    <= '0;
      prev_q      <= '0;
      pulse_q     <= '0;
      db_cnt_q[0] <= '0;
      db_cnt_q[1] <= '0;
    end else begin
      sync1_q     <= raw;
      sync2_q     <= sync1_q;
      stable_q    <= stable_d;
      prev_q      <= stable_q;
      pulse_q     <= pulse_d;
      db_cnt_q[0] <= db_cnt_d[0];
      db_cnt_q[1] <= db_cnt_d[1];
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      stable_d[i] = stable_q[i];
      db_cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) stable_d[i] = sync2_q[i];
        else                        db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
    end
  end

  // A fresh press only counts while the opposite button is released.
  assign edge_det = stable_q & ~prev_q & ~other_held;

`ifdef AUTOREPEAT_EN
  localparam int RMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] HOLD_LAST   = RW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] REPEAT_LAST = RW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} rpt_state_e;

  rpt_state_e    state_q [2];
  rpt_state_e    state_d [2];
  logic [RW-1:0] rpt_cnt_q [2];
  logic [RW-1:0] rpt_cnt_d [2];

  always_ff @(posedge clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state_q[0]   <= IDLE;
      state_q[1]   <= IDLE;
      rpt_cnt_q[0] <= '0;
      rpt_cnt_q[1] <= '0;
    end else begin
      state_q[0]   <= state_d[0];
      state_q[1]   <= state_d[1];
      rpt_cnt_q[0] <= rpt_cnt_d[0];
      rpt_cnt_q[1] <= rpt_cnt_d[1];
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i]   = state_q[i];
      rpt_cnt_d[i] = rpt_cnt_q[i];
      rpt_pulse[i] = 1'b0;
      case (state_q[i])
        IDLE: begin
          if (edge_det[i]) begin
            state_d[i]   = HOLD;
            rpt_cnt_d[i] = '0;
          end
        end
        HOLD, REPEAT: begin
          // Abort takes priority over a pulse due on the same edge.
          if (!stable_q[i] || other_held[i]) begin
            state_d[i]   = IDLE;
            rpt_cnt_d[i] = '0;
          end else if (rpt_cnt_q[i] == ((state_q[i] == HOLD) ? HOLD_LAST : REPEAT_LAST)) begin
            state_d[i]   = REPEAT;
            rpt_cnt_d[i] = '0;
            rpt_pulse[i] = 1'b1;
          end else begin
            rpt_cnt_d[i] = rpt_cnt_q[i] + 1'b1;
          end
        end
        default: begin
          state_d[i]   = IDLE;
          rpt_cnt_d[i] = '0;
        end
      endcase
    end
  end
`else
  assign rpt_pulse = 2'b00;
`endif

  assign pulse_d    = edge_det | rpt_pulse;

  assign up_pulse   = pulse_q[0];
  assign down_pulse = pulse_q[1];
  assign up_held    = stable_q[0];
  assign down_held  = stable_q[1];

endmodule

// File: tb/tb_updown_pulse_gen.sv
// Directed self-checking bench for updown_pulse_gen (DB=4, HOLD=10, REPEAT=3).
module tb_updown_pulse_gen;
  logic clk = 1'b0;
  logic sys_reset_n = 1'b0;
  logic btn_up_raw = 1'b0;
  logic btn_down_raw = 1'b0;
  logic up_pulse, down_pulse, up_held, down_held;

  int n_checks = 0;
  int n_err = 0;
  int up_cnt = 0;
  int dn_cnt = 0;
  int both_cnt = 0;

  updown_pulse_gen #(.DB_CYCLES(4), .HOLD_CYCLES(10), .REPEAT_CYCLES(3)) dut (
    .clk(clk), .sys_reset_n(sys_reset_n),
    .btn_up_raw(btn_up_raw), .btn_down_raw(btn_down_raw),
    .up_pulse(up_pulse), .down_pulse(down_pulse),
    .up_held(up_held), .down_held(down_held)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (up_pulse) up_cnt++;
    if (down_pulse) dn_cnt++;
    if (up_pulse && down_pulse) both_cnt++;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int u0, d0, seen;

    // Reset state
    step(3);
    chk("rst_up_pulse", up_pulse, 0);
    chk("rst_down_pulse", down_pulse, 0);
    chk("rst_up_held", up_held, 0);
    chk("rst_down_held", down_held, 0);
    sys_reset_n = 1'b1;
    step(3);

    // Clean press with exact latency
    u0 = up_cnt; d0 = dn_cnt;
    btn_up_raw = 1'b1;
    step(5);
    chk("clean_held_early", up_held, 0);
    step(1);
    chk("clean_held_rise", up_held, 1);
    chk("clean_pulse_early", up_pulse, 0);
    step(1);
    chk("clean_pulse_on", up_pulse, 1);
    step(1);
    chk("clean_pulse_off", up_pulse, 0);
    step(22);
`ifndef AUTOREPEAT_EN
    chk("clean_one_pulse", up_cnt - u0, 1);
`endif
    chk("clean_no_down", dn_cnt - d0, 0);
    u0 = up_cnt;
    btn_up_raw = 1'b0;
    step(10);
    chk("release_held", up_held, 0);
    chk("release_no_pulse", up_cnt - u0, 0);

    // Bounce rejection
    d0 = dn_cnt; seen = 0;
    for (int i = 0; i < 8; i++) begin
      btn_down_raw = (i % 2 == 0);
      step(1);
      seen |= down_held;
    end
    btn_down_raw = 1'b1;
    step(3);
    seen |= down_held;
    btn_down_raw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      seen |= down_held;
    end
    chk("bounce_held", seen, 0);
    chk("bounce_pulse", dn_cnt - d0, 0);

    // Simultaneous press
    u0 = up_cnt; d0 = dn_cnt;
    btn_up_raw = 1'b1; btn_down_raw = 1'b1;
    step(20);
    chk("simul_up_held", up_held, 1);
    chk("simul_down_held", down_held, 1);
    chk("simul_up_pulse", up_cnt - u0, 0);
    chk("simul_down_pulse", dn_cnt - d0, 0);
    btn_down_raw = 1'b0;
    step(10);
    chk("simul_down_rel", down_held, 0);
    chk("simul_up_after_rel", up_cnt - u0, 0);
    btn_up_raw = 1'b0;
    step(10);

    // Overlap: Up held, Down pressed, then Down re-pressed alone
    u0 = up_cnt; d0 = dn_cnt;
    btn_up_raw = 1'b1;
    step(8);
    chk("ovl_up_pulse", up_cnt - u0, 1);
    btn_down_raw = 1'b1;
    step(10);
    chk("ovl_down_held", down_held, 1);
    chk("ovl_no_down", dn_cnt - d0, 0);
    btn_up_raw = 1'b0;
    step(10);
    chk("ovl_up_rel", up_held, 0);
    btn_down_raw = 1'b0;
    step(10);
    chk("ovl_still_no_down", dn_cnt - d0, 0);
    btn_down_raw = 1'b1;
    step(10);
    chk("ovl_down_once", dn_cnt - d0, 1);
    btn_down_raw = 1'b0;
    step(10);

    // Async reset mid-debounce
    u0 = up_cnt;
    btn_up_raw = 1'b1;
    step(3);
    #2 sys_reset_n = 1'b0;
    #1;
    chk("arst_up_held", up_held, 0);
    chk("arst_up_pulse", up_pulse, 0);
    #1 sys_reset_n = 1'b1;
    step(1);
    step(4);
    chk("arst_redb_early", up_held, 0);
    step(1);
    chk("arst_redb_held", up_held, 1);
    step(1);
    chk("arst_redb_pulse", up_pulse, 1);
    chk("arst_one_pulse", up_cnt - u0, 1);
    // Reset while held clears the level at once
    #2 sys_reset_n = 1'b0;
    #1;
    chk("arst_held_clear", up_held, 0);
    #1 sys_reset_n = 1'b1;
    btn_up_raw = 1'b0;
    step(10);

`ifdef AUTOREPEAT_EN
    // Hold-to-repeat: first pulse at P, then P+10, P+13, P+16
    btn_up_raw = 1'b1;
    step(7);
    chk("rpt_first", up_pulse, 1);
    step(9);
    chk("rpt_gap", up_pulse, 0);
    step(1);
    chk("rpt_p10", up_pulse, 1);
    step(3);
    chk("rpt_p13", up_pulse, 1);
    step(3);
    chk("rpt_p16", up_pulse, 1);
    btn_down_raw = 1'b1;
    step(6);
    u0 = up_cnt; d0 = dn_cnt;
    step(15);
    chk("rpt_halt_up", up_cnt - u0, 0);
    chk("rpt_halt_down", dn_cnt - d0, 0);
    btn_down_raw = 1'b0;
    step(10);
    chk("rpt_no_restart", up_cnt - u0, 0);
    btn_up_raw = 1'b0;
    step(6);
    u0 = up_cnt;
    step(10);
    chk("rpt_stop_release", up_cnt - u0, 0);
`endif

    chk("never_both", both_cnt, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
